// File: rtl/uart_rx.sv
// UART receive path: 8N1 frames, LSB first, fixed clocks-per-bit timing.
// Emits each good byte with a one-cycle rx_valid, a bad stop bit with a one-cycle framing_error.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    logic             r_rx_meta;
    logic             r_rx_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_sr;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_framing_error;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       w_sr_nxt;
    logic [7:0]       w_rx_data_nxt;
    logic             w_rx_valid_nxt;
    logic             w_framing_error_nxt;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_bit_idx       <= '0;
            r_sr            <= '0;
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_bit_idx       <= w_bit_idx_nxt;
            r_sr            <= w_sr_nxt;
            r_rx_data       <= w_rx_data_nxt;
            r_rx_valid      <= w_rx_valid_nxt;
            r_framing_error <= w_framing_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt;
        w_bit_idx_nxt       = r_bit_idx;
        w_sr_nxt            = r_sr;
        w_rx_data_nxt       = r_rx_data;
        w_rx_valid_nxt      = 1'b0;
        w_framing_error_nxt = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = '0;
                end
            end
            // Re-check the line at mid start bit; a high here was only a glitch
            START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_nxt = '0;
                    if (!r_rx_s) begin
                        w_state_nxt   = DATA;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (r_cnt == BIT_M1) begin
                    w_cnt_nxt = '0;
                    w_sr_nxt  = {r_rx_s, r_sr[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            // Leaving mid stop bit lets a directly following start bit be caught
            STOP: begin
                if (r_cnt == BIT_M1) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_rx_data_nxt  = r_sr;
                        w_rx_valid_nxt = 1'b1;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_framing_error_nxt = 1'b1;
                        w_state_nxt         = WAIT_HIGH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (r_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign framing_error = r_framing_error;
    assign busy          = (r_state != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive path: recovers 8-bit frames (1 start bit, 8 data bits LSB-first, 1 stop bit, no parity) from the asynchronous serial line and presents each byte with a one-cycle valid strobe. It sits at the RX pin of the UART and mirrors the TX parallel-in/serial-out path: the bit order and framing it accepts are exactly what the transmitter emits. Timing is derived internally from a fixed clocks-per-bit count; no external baud tick is used.

## Interface
- CLKS_PER_BIT, 16: system clocks per serial bit; integer ≥ 4. HALF = CLKS_PER_BIT/2, using integer division.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  8  last correctly received byte; holds between frames.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- framing_error  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- rx passes through a 2-flop synchronizer; both flops reset to 1. Call its output rx_s.
- Registers: cnt (counts up to CLKS_PER_BIT-1), bit_idx (0..7), shift register sr[7:0].
- FSM states and transitions:
  - IDLE: when rx_s=0, go to START with cnt=0. Otherwise stay.
  - START: cnt increments each cycle. When cnt==HALF-1, sample rx_s. If it is 0, go to DATA with cnt=0 and bit_idx=0. If it is 1, the low was a glitch: return to IDLE with no output.
  - DATA: cnt increments. When cnt==CLKS_PER_BIT-1, shift sr <= {rx_s, sr[7:1]} (LSB arrives first) and set cnt=0. After the sample with bit_idx==7, go to STOP; otherwise increment bit_idx.
  - STOP: cnt increments. When cnt==CLKS_PER_BIT-1, sample rx_s. If it is 1: rx_data<=sr, pulse rx_valid, go to IDLE. If it is 0: pulse framing_error, leave rx_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This covers a break or a stuck-low line and prevents false starts.
- busy = (state != IDLE).
- rx_valid and framing_error are registered, mutually exclusive, and each is high for exactly one cycle per frame.

## Timing
- Reset values: rx_data=8'h00, rx_valid=0, framing_error=0, busy=0. state=IDLE, cnt=0, bit_idx=0, sr=0, synchronizer flops=1.
- rst has priority over every other event. Asserting rst mid-frame abandons the frame with no valid or error pulse. Once rst deasserts, the first edge that can leave IDLE is the next one on which rx_s=0.
- rx_s equals rx delayed by 2 clock edges.
- Let E0 be the edge at which IDLE sees rx_s=0.
  - Start-bit check happens at edge E0+HALF.
  - Data bit k (k=0..7) is sampled at edge E0+HALF+(k+1)·CLKS_PER_BIT.
  - The stop bit is sampled at edge E0+HALF+9·CLKS_PER_BIT. rx_valid or framing_error is high in the cycle after that edge.
  - With CLKS_PER_BIT=16, rx_valid is high after edge E0+152.
- Back-to-back frames: the FSM returns to IDLE in the same edge as the valid pulse, mid-stop-bit. A start bit that begins immediately after the stop bit is therefore captured with no lost frame.
- A start glitch shorter than HALF cycles (measured at rx_s) is rejected. busy is high for HALF cycles during the glitch and then drops.
- rx_data changes only on a valid frame.

## Test plan
- Frame 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1) at 16 clk/bit: rx_valid pulses for exactly 1 cycle at E0+152 with rx_data=0xA5; framing_error stays 0.
- Low glitch of 3 cycles on an idle line: no rx_valid, no framing_error, busy returns to 0 after HALF cycles, and rx_data keeps its prior value.
- Frame 0x3C with stop bit driven 0, line held low for 40 further cycles and then released: framing_error pulses once, rx_data is unchanged, and busy stays high until 2 cycles after the line returns high.
- Back-to-back frames 0x00 then 0xFF with no idle gap: two rx_valid pulses exactly 10·CLKS_PER_BIT cycles apart, carrying 0x00 then 0xFF.
- rst asserted during data bit 4 of a 0x81 frame, then frame 0x5A sent: no output for 0x81, all outputs at their reset values, then a single rx_valid with rx_data=0x5A.
- CLKS_PER_BIT=5 (odd, HALF=2), frame 0xC3: rx_valid at E0+47 with rx_data=0xC3.
